// File: rtl/serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_pkg : shared types and helpers for the bit-serial adder       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit so the counter can represent WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_if : operand/result handshake bundle for serial_adder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/fa_using_ha.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fa_using_ha : single-bit full adder built from two half-adder stages |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fa_using_ha (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic w_ha0_sum;
  logic w_ha0_carry;
  logic w_ha1_carry;

  assign w_ha0_sum   = a ^ b;
  assign w_ha0_carry = a & b;

  assign sum         = w_ha0_sum ^ cin;
  assign w_ha1_carry = w_ha0_sum & cin;

  assign carry       = w_ha0_carry | w_ha1_carry;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder : LSB-first bit-serial adder, one bit per clock         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int                  c_cnt_w    = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_out_valid;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_release;
  logic               w_last;
  logic               w_fa_sum;
  logic               w_fa_carry;
  logic [WIDTH-1:0]   w_sum_next;

  assign w_in_ready = (r_state == IDLE) && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_release  = r_out_valid && bus.out_ready;
  assign w_last     = (r_cnt == c_cnt_last);

  fa_using_ha u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .cin   (r_carry),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  // The partial-sum shifter only needs WIDTH-1 stored bits: the newest bit
  // comes straight from the full adder when the result is captured.
  if (WIDTH == 1) begin : g_w1
    assign w_sum_next = w_fa_sum;
  end else begin : g_wn
    logic [WIDTH-2:0] r_sum_sh;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum_sh <= '0;
      end else if (w_accept) begin
        r_sum_sh <= '0;
      end else if (r_state == RUN) begin
        r_sum_sh <= w_sum_next[WIDTH-1:1];
      end
    end

    assign w_sum_next = {w_fa_sum, r_sum_sh};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_fa_carry;
          r_cnt   <= r_cnt + c_cnt_one;
          // Result registers update only here, so they hold between operations.
          if (w_last) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_fa_carry;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (w_release) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's single-bit full-adder cell.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Adds LSB-first, one bit per clock, through one full-adder instance and a registered carry.
- Presents the WIDTH-bit sum and carry-out on a valid/ready output handshake.
- Sits directly downstream of the full-adder cell: it is the consumer that chains that cell's sum/carry over time.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range is 1 or more.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum and cout are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state=IDLE; out_valid=0; sum=0; cout=0; busy=0; internal shift registers, carry register and bit counter all 0.
- in_ready = (state==IDLE) && !rst, combinational. It is low while rst is high.
- States are IDLE, RUN and DONE.
- IDLE:
  - On an edge with in_valid && in_ready, load a_sh=a, b_sh=b, carry=cin, cnt=0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, every cycle:
  - The full adder takes (a_sh[0], b_sh[0], carry).
  - Its sum bit shifts into the MSB of sum_sh, with a right shift.
  - carry <= full-adder carry.
  - a_sh and b_sh shift right by one.
  - cnt increments.
- RUN exit: on the edge where cnt==WIDTH-1:
  - sum <= the completed shifted result, including this cycle's bit;
  - cout <= this cycle's full-adder carry;
  - out_valid <= 1;
  - go to DONE.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. For WIDTH=1 that is one RUN cycle.
- DONE:
  - out_valid=1.
  - sum and cout are held stable.
  - in_ready=0; in_valid is ignored and the source must hold its data.
  - On an edge with out_valid && out_ready, set out_valid <= 0 and go to IDLE. in_ready reasserts the next cycle.
  - No back-to-back accept in the same edge.
- sum and cout change only on the RUN-to-DONE edge or on reset. Between operations they keep the last result.
- in_valid during RUN is ignored, since in_ready is low.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid pulse, and all state returns to reset values on that edge.
- Width rules:
  - cnt width is $clog2(WIDTH)+1.
  - The full add is modulo 2^WIDTH, with the overflow bit on cout.
  - No X may propagate from unloaded shift registers.

Decomposition:
- Shared package serial_pkg holds the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a localparam helper for the counter width.
- One sub-module, the existing single-bit full-adder cell fa_using_ha. It is instantiated once with ports (a, b, cin, sum, carry) and performs all arithmetic.
- No adder arithmetic is inferred with "+" in this block.

Test Plan:
1. Reset: rst=1 for 2 cycles, then release -> out_valid=0, sum=0, cout=0, busy=0, in_ready=1.
2. WIDTH=8, a=8'h5A, b=8'h33, cin=0 -> out_valid exactly 8 cycles after accept, sum=8'h8D, cout=0.
3. Carry extremes:
   - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
   - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
   - a=0, b=0, cin=1 -> sum=8'h01, cout=0.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stable, in_ready=0.
   - Drive in_valid with new operands during this window -> they are ignored.
   - After the handshake, the next cycle shows in_ready=1 and busy=0.
5. Reset mid-operation: assert rst on the 3rd RUN cycle -> no out_valid, back to IDLE, outputs 0. The next operation, a=8'h10, b=8'h20, cin=0, gives sum=8'h30, cout=0.
6. Exhaustive check with WIDTH=2: all 32 combinations of (a, b, cin) -> {cout, sum} equals a+b+cin, out_valid arrives after 2 cycles each time. Also WIDTH=1 with all 8 combinations and 1-cycle latency.
